// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: double-dabble binary-to-BCD converter feeding a 4-digit multiplexed FND scan.
// Define FND_LZ_BLANK_EN to blank leading zero digits.
module fnd_scan_controller #(
  parameter int TICK_DIV = 100000,
  parameter int TICK_W   = 17
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [13:0] i_value,
  input  logic        i_load,
  input  logic        i_en,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_digitSelect,
  output logic [3:0]  o_sum,
  output logic        o_en
);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t r_state, w_next;
  logic [TICK_W-1:0] r_presc;
  logic [1:0]  r_scan;
  logic [15:0] r_disp, r_bcd, w_adj;
  logic [13:0] r_bin;
  logic [3:0]  r_cnt;
  logic        r_en, r_done, w_tick, w_blank;
  assign w_tick = r_presc == TICK_W'(TICK_DIV - 1);
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_presc <= '0;
      r_scan  <= '0;
      r_en    <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      r_scan  <= r_scan + {1'b0, w_tick};
      r_en    <= i_en;
    end
  end
  for (genvar n = 0; n < 4; n++) begin : g_adj
    assign w_adj[4*n +: 4] = r_bcd[4*n +: 4] >= 4'd5 ? r_bcd[4*n +: 4] + 4'd3 : r_bcd[4*n +: 4];
  end
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = i_load ? SHIFT : IDLE;
    else if (r_state == SHIFT) w_next = r_cnt == 4'd13 ? COMMIT : SHIFT;
    else w_next = IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_disp  <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= r_state == COMMIT;
      if (r_state == COMMIT) r_disp <= r_bcd;
    end
  end
  // scratch path needs no reset: it is always reinitialised on acceptance
  always_ff @(posedge i_clk) begin
    if (r_state == IDLE && i_load) begin
      r_bin <= i_value > 14'd9999 ? 14'd9999 : i_value;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_bcd <= {w_adj[14:0], r_bin[13]};
      r_bin <= r_bin << 1;
      r_cnt <= r_cnt + 4'd1;
    end
  end
`ifdef FND_LZ_BLANK_EN
  assign w_blank = r_scan != 2'd0 && (r_disp >> {r_scan, 2'b00}) == 16'd0;
`else
  assign w_blank = 1'b0;
`endif
  assign o_busy        = r_state != IDLE;
  assign o_done        = r_done;
  assign o_digitSelect = r_scan;
  assign o_sum         = r_disp[{r_scan, 2'b00} +: 4];
  assign o_en          = r_en & ~w_blank;
endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb_fnd_scan_controller: scoreboard bench; expected digits queued at load, checked on each o_done.
module tb_fnd_scan_controller;
  logic        clk = 1'b0;
  logic        i_reset, i_load, i_en;
  logic [13:0] i_value;
  logic        o_busy, o_done, o_en;
  logic [1:0]  o_digitSelect;
  logic [3:0]  o_sum;
  int ncmp = 0, nerr = 0, ndone = 0, d0;
  logic [15:0] q[$];
  logic [15:0] e;

  fnd_scan_controller #(.TICK_DIV(4), .TICK_W(3)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_value(i_value), .i_load(i_load), .i_en(i_en),
    .o_busy(o_busy), .o_done(o_done), .o_digitSelect(o_digitSelect), .o_sum(o_sum), .o_en(o_en)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic exp_en(logic [15:0] d, logic [1:0] k);
`ifdef FND_LZ_BLANK_EN
    return k == 2'd0 || (d >> (4 * k)) != 16'd0;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk) begin
    #1;
    if (o_done) begin
      ndone++;
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("done_digit", o_sum, e[4*o_digitSelect +: 4]);
      end
    end
  end

  task automatic load(logic [13:0] v, logic [15:0] exp);
    i_value = v;
    i_load  = 1'b1;
    q.push_back(exp);
    tick();
    i_load = 1'b0;
  endtask

  task automatic wait_done(string name);
    for (int k = 0; k < 40 && !o_done; k++) tick();
    chk(name, o_done, 1);
  endtask

  task automatic sweep(logic [15:0] d, int n);
    logic [1:0] ps, nx;
    int run;
    bit first;
    ps = o_digitSelect;
    run = 0;
    first = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (o_digitSelect != ps) begin
        nx = ps + 2'd1;
        chk("scan_step", o_digitSelect, nx);
        if (!first) chk("scan_hold", run, 4);
        first = 1'b0;
        run = 0;
        ps = o_digitSelect;
      end
      run++;
      chk("slot_sum", o_sum, d[4*o_digitSelect +: 4]);
      chk("slot_en", o_en, exp_en(d, o_digitSelect));
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    i_reset = 1'b1; i_load = 1'b0; i_en = 1'b0; i_value = '0;
    tick(2);
    chk("rst_sel", o_digitSelect, 0);
    chk("rst_sum", o_sum, 0);
    chk("rst_en", o_en, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    i_reset = 1'b0;
    i_en = 1'b1;
    chk("en_latency0", o_en, 0);
    tick();
    chk("en_latency1", o_en, 1);
    chk("presc_sel1", o_digitSelect, 0);
    tick(2);
    chk("presc_sel3", o_digitSelect, 0);
    tick();
    chk("presc_wrap", o_digitSelect, 1);
    // 1234: busy window and first done
    load(14'd1234, 16'h1234);
    for (int j = 1; j <= 15; j++) begin
      chk("busy_window", o_busy, 1);
      chk("no_early_done", o_done, 0);
      tick();
    end
    chk("busy_end", o_busy, 0);
    chk("done_n16", o_done, 1);
    sweep(16'h1234, 24);
    // saturation
    load(14'd16383, 16'h9999);
    wait_done("done_16383");
    sweep(16'h9999, 16);
    load(14'd10000, 16'h9999);
    wait_done("done_10000");
    sweep(16'h9999, 16);
    // load while busy is ignored
    d0 = ndone;
    load(14'd1234, 16'h1234);
    tick(4);
    i_value = 14'd42;
    i_load = 1'b1;
    tick();
    i_load = 1'b0;
    wait_done("done_t4");
    sweep(16'h1234, 32);
    chk("t4_one_done", ndone - d0, 1);
    // reset mid-conversion
    d0 = ndone;
    i_value = 14'd5678;
    i_load = 1'b1;
    tick();
    i_load = 1'b0;
    tick(6);
    i_reset = 1'b1;
    tick();
    chk("abort_busy", o_busy, 0);
    chk("abort_done", o_done, 0);
    i_reset = 1'b0;
    tick();
    sweep(16'h0000, 24);
    chk("abort_no_done", ndone - d0, 0);
    // held load re-accepted on first idle cycle
    i_value = 14'd321;
    i_load = 1'b1;
    q.push_back(16'h0321);
    tick(16);
    chk("held_done", o_done, 1);
    i_value = 14'd55;
    q.push_back(16'h0055);
    tick();
    i_load = 1'b0;
    chk("held_busy", o_busy, 1);
    wait_done("done_held");
    sweep(16'h0055, 16);
    // leading zero handling
    load(14'd7, 16'h0007);
    wait_done("done_7");
    sweep(16'h0007, 16);
    load(14'd0, 16'h0000);
    wait_done("done_0");
    sweep(16'h0000, 16);
    chk("queue_empty", q.size(), 0);
    chk("done_total", ndone, 8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
